// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, the canonical NOP and the fetch-stage enums.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE
    } ifid_ctrl_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it, or replaces it with a NOP bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int TAM_DATA = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  ifid_ctrl_t          ctrl,
    input  logic [TAM_DATA-1:0] pc_in,
    input  logic [TAM_DATA-1:0] pc4_in,
    input  logic [TAM_DATA-1:0] instr_in,
    output logic [TAM_DATA-1:0] pc,
    output logic [TAM_DATA-1:0] pc4,
    output logic [TAM_DATA-1:0] instr,
    output logic                valid
);

    // A bubble only kills the instruction; the PC fields are don't-care for decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            pc4   <= TAM_DATA'(4);
            instr <= TAM_DATA'(NOP_INSTR);
            valid <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    pc    <= pc_in;
                    pc4   <= pc4_in;
                    instr <= instr_in;
                    valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    instr <= TAM_DATA'(NOP_INSTR);
                    valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC selection, RUN/HALT FSM and IF/ID register.
// Define FETCH_STATS_EN to add saturating INSTR_COUNT / BUBBLE_COUNT outputs.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                  TAM_DATA = 32,
    parameter int                  TAM_ADDR = 10,
    parameter logic [TAM_DATA-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic                PCSRC,
    input  logic [TAM_DATA-1:0] TARGET,
    output logic [TAM_ADDR-1:0] IMEM_ADDR,
    input  logic [TAM_DATA-1:0] IMEM_DATA,
    output logic [TAM_DATA-1:0] PC_IF_ID,
    output logic [TAM_DATA-1:0] PC4_IF_ID,
    output logic [TAM_DATA-1:0] INSTR_IF_ID,
    output logic [6:0]          OPCODE_IF_ID,
    output logic                VALID_IF_ID,
    output logic                HALTED
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         INSTR_COUNT,
    output logic [31:0]         BUBBLE_COUNT
`endif
);

    localparam logic [TAM_DATA-1:0] ALIGN_MASK = {{(TAM_DATA-2){1'b1}}, 2'b00};

    logic [TAM_DATA-1:0] pc_q;
    logic [TAM_DATA-1:0] pc_next;
    logic [TAM_DATA-1:0] pc_plus4;
    logic [TAM_DATA-1:0] target_aligned;
    fetch_state_t        state;
    ifid_ctrl_t          ifid_ctrl;
    logic                halt_hit;

    // The IMEM samples IMEM_ADDR on the same edge that loads pc_q, so its data always matches pc_q.
    always_comb begin
        pc_plus4       = pc_q + TAM_DATA'(4);
        target_aligned = TARGET & ALIGN_MASK;
        pc_next        = pc_plus4;
        ifid_ctrl      = IFID_LOAD;

        if (RESET) begin
            pc_next = RESET_PC;
        end else if (PCSRC) begin
            pc_next = target_aligned;
        end else if (STALL || state == HALT) begin
            pc_next = pc_q;
        end

        // A redirect kills the wrong-path fetch even while decode is stalled.
        if (PCSRC) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (STALL) begin
            ifid_ctrl = IFID_HOLD;
        end else if (state == HALT) begin
            ifid_ctrl = IFID_BUBBLE;
        end
    end

    assign IMEM_ADDR = pc_next[TAM_ADDR+1:2];
    assign halt_hit  = (ifid_ctrl == IFID_LOAD) && (opcode_of(32'(IMEM_DATA)) == OPC_SYSTEM);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q   <= RESET_PC;
            state  <= RUN;
            HALTED <= 1'b0;
        end else begin
            pc_q <= pc_next;
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= HALT;
                        HALTED <= 1'b1;
                    end
                end
                HALT: begin
                    if (PCSRC) begin
                        state  <= RUN;
                        HALTED <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    HALTED <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .TAM_DATA(TAM_DATA)
    ) u_if_id (
        .clk     (CLK),
        .reset   (RESET),
        .ctrl    (ifid_ctrl),
        .pc_in   (pc_q),
        .pc4_in  (pc_plus4),
        .instr_in(IMEM_DATA),
        .pc      (PC_IF_ID),
        .pc4     (PC4_IF_ID),
        .instr   (INSTR_IF_ID),
        .valid   (VALID_IF_ID)
    );

    assign OPCODE_IF_ID = INSTR_IF_ID[6:0];

`ifdef FETCH_STATS_EN
    // Stall holds count as bubbles: decode sees no new instruction that cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INSTR_COUNT  <= '0;
            BUBBLE_COUNT <= '0;
        end else begin
            if (ifid_ctrl == IFID_LOAD && INSTR_COUNT != '1) begin
                INSTR_COUNT <= INSTR_COUNT + 32'd1;
            end
            if (ifid_ctrl != IFID_LOAD && BUBBLE_COUNT != '1) begin
                BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a synchronous IMEM model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_if_id;
    logic [31:0] pc4_if_id;
    logic [31:0] instr_if_id;
    logic [6:0]  opcode_if_id;
    logic        valid_if_id;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] instr_count;
    logic [31:0] bubble_count;
`endif

    logic [31:0] mem [1024];

    int passed = 0;
    int total  = 0;

    fetch_stage dut (
        .CLK         (clk),
        .RESET       (reset),
        .STALL       (stall),
        .PCSRC       (pcsrc),
        .TARGET      (target),
        .IMEM_ADDR   (imem_addr),
        .IMEM_DATA   (imem_data),
        .PC_IF_ID    (pc_if_id),
        .PC4_IF_ID   (pc4_if_id),
        .INSTR_IF_ID (instr_if_id),
        .OPCODE_IF_ID(opcode_if_id),
        .VALID_IF_ID (valid_if_id),
        .HALTED      (halted)
`ifdef FETCH_STATS_EN
        ,
        .INSTR_COUNT (instr_count),
        .BUBBLE_COUNT(bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    // Distinct non-NOP ITYPE word per address.
    function automatic logic [31:0] word_at(input int idx);
        return (32'(idx) << 12) | 32'h0000_0093;
    endfunction

    typedef struct {
        string       name;
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic [9:0]  exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[11];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic s, input logic p, input logic [31:0] t);
        stall  = s;
        pcsrc  = p;
        target = t;
        #1;
    endtask

    task automatic check_bubble(input string name);
        check_output({name, "_valid"}, 32'(valid_if_id), 32'd0);
        check_output({name, "_instr"}, instr_if_id, 32'h0000_0013);
    endtask

    task automatic check_instr(input string name, input logic [31:0] pc, input logic [31:0] instr);
        check_output({name, "_valid"}, 32'(valid_if_id), 32'd1);
        check_output({name, "_pc"}, pc_if_id, pc);
        check_output({name, "_pc4"}, pc4_if_id, pc + 32'd4);
        check_output({name, "_instr"}, instr_if_id, instr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(i);

        vecs[0]  = '{"run0",      1'b0, 1'b0, 32'h0,  10'd1,  32'h00, word_at(0),  1'b1};
        vecs[1]  = '{"run4",      1'b0, 1'b0, 32'h0,  10'd2,  32'h04, word_at(1),  1'b1};
        vecs[2]  = '{"run8",      1'b0, 1'b0, 32'h0,  10'd3,  32'h08, word_at(2),  1'b1};
        vecs[3]  = '{"stall1",    1'b1, 1'b0, 32'h0,  10'd3,  32'h08, word_at(2),  1'b1};
        vecs[4]  = '{"stall2",    1'b1, 1'b0, 32'h0,  10'd3,  32'h08, word_at(2),  1'b1};
        vecs[5]  = '{"resume12",  1'b0, 1'b0, 32'h0,  10'd4,  32'h0C, word_at(3),  1'b1};
        vecs[6]  = '{"run16",     1'b0, 1'b0, 32'h0,  10'd5,  32'h10, word_at(4),  1'b1};
        vecs[7]  = '{"redir_stl", 1'b1, 1'b1, 32'h40, 10'd16, 32'h0,  32'h13,      1'b0};
        vecs[8]  = '{"tgt40",     1'b0, 1'b0, 32'h0,  10'd17, 32'h40, word_at(16), 1'b1};
        vecs[9]  = '{"redir43",   1'b0, 1'b1, 32'h43, 10'd16, 32'h0,  32'h13,      1'b0};
        vecs[10] = '{"tgt43",     1'b0, 1'b0, 32'h0,  10'd17, 32'h40, word_at(16), 1'b1};

        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rst_addr", 32'(imem_addr), 32'd0);
        tick();
        tick();
        check_output("rst_pc", pc_if_id, 32'h0);
        check_output("rst_pc4", pc4_if_id, 32'h4);
        check_output("rst_instr", instr_if_id, 32'h0000_0013);
        check_output("rst_opcode", 32'(opcode_if_id), 32'h13);
        check_output("rst_valid", 32'(valid_if_id), 32'd0);
        check_output("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].stall, vecs[i].pcsrc, vecs[i].target);
            check_output({vecs[i].name, "_addr"}, 32'(imem_addr), 32'(vecs[i].exp_addr));
            tick();
            check_output({vecs[i].name, "_valid"}, 32'(valid_if_id), 32'(vecs[i].exp_valid));
            check_output({vecs[i].name, "_instr"}, instr_if_id, vecs[i].exp_instr);
            if (vecs[i].exp_valid) begin
                check_output({vecs[i].name, "_pc"}, pc_if_id, vecs[i].exp_pc);
                check_output({vecs[i].name, "_pc4"}, pc4_if_id, vecs[i].exp_pc + 32'd4);
            end
        end

        // ECALL at 0x10 halts fetch until a redirect.
        mem[4] = 32'h0000_0073;
        apply_stimulus(1'b0, 1'b1, 32'h10);
        tick();
        check_bubble("ecall_redir");
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        check_instr("ecall_load", 32'h10, 32'h0000_0073);
        check_output("ecall_opcode", 32'(opcode_if_id), 32'h73);
        check_output("ecall_halted", 32'(halted), 32'd1);
        check_output("halt_addr", 32'(imem_addr), 32'd5);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick();
        check_instr("halt_stall", 32'h10, 32'h0000_0073);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        check_bubble("halt_bub1");
        check_output("halt_hold", 32'(halted), 32'd1);
        check_output("halt_addr2", 32'(imem_addr), 32'd5);
        tick();
        check_bubble("halt_bub2");
        apply_stimulus(1'b0, 1'b1, 32'h20);
        check_output("unhalt_addr", 32'(imem_addr), 32'd8);
        tick();
        check_bubble("unhalt_bub");
        check_output("unhalt_halted", 32'(halted), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        check_instr("unhalt_run", 32'h20, word_at(8));

        // IMEM word address wraps 1023 -> 0.
        apply_stimulus(1'b0, 1'b1, 32'hFF8);
        tick();
        check_bubble("wrap_redir");
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_addr1023", 32'(imem_addr), 32'd1023);
        tick();
        check_instr("wrap_ff8", 32'hFF8, word_at(1022));
        check_output("wrap_addr0", 32'(imem_addr), 32'd0);
        tick();
        check_instr("wrap_ffc", 32'hFFC, word_at(1023));
        tick();
        check_instr("wrap_1000", 32'h1000, word_at(0));

        // Reset mid-operation beats a simultaneous redirect.
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 32'h80);
        check_output("mrst_addr", 32'(imem_addr), 32'd0);
        tick();
        check_output("mrst_pc", pc_if_id, 32'h0);
        check_output("mrst_pc4", pc4_if_id, 32'h4);
        check_bubble("mrst");
`ifdef FETCH_STATS_EN
        check_output("stat_rst_instr", instr_count, 32'd0);
        check_output("stat_rst_bubble", bubble_count, 32'd0);
`endif
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        check_instr("mrst_first", 32'h0, word_at(0));
        tick();
        tick();
        tick();
        check_instr("mrst_run12", 32'hC, word_at(3));
        apply_stimulus(1'b0, 1'b1, 32'h20);
        tick();
        check_bubble("stat_redir");
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        check_instr("stat_tgt", 32'h20, word_at(8));
`ifdef FETCH_STATS_EN
        check_output("stat_instr", instr_count, 32'd5);
        check_output("stat_bubble", bubble_count, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
